// File: rtl/decode_sched_pkg.sv
// decode_sched shared types and constants.
// Instruction width, NOP encoding, load opcode and scoreboard states.
package decode_sched_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [6:0] OPC_LOAD = 7'b000_0011;

    typedef enum logic {
        SCHED_RUN    = 1'b0,
        SCHED_SHADOW = 1'b1
    } sched_state_t;

endpackage

// File: rtl/decode_sched_if.sv
// Fetch-to-decode handshake bundle for decode_sched.
// master = surrounding stage, slave = decode_sched.
interface decode_sched_if;
    import decode_sched_pkg::*;

    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            if_ready;
    logic            ex_ready;
    logic [4:0]      dec_adr1;
    logic [4:0]      dec_adr2;
    logic            dec_valid;
    logic [XLEN-1:0] dec_instr;
    logic [XLEN-1:0] dec_pc;
    logic            dec_stall;

    modport master (
        output if_valid, if_instr, if_pc,
        output ex_ready, dec_adr1, dec_adr2,
        input  if_ready, dec_valid, dec_instr,
        input  dec_pc, dec_stall
    );

    modport slave (
        input  if_valid, if_instr, if_pc,
        input  ex_ready, dec_adr1, dec_adr2,
        output if_ready, dec_valid, dec_instr,
        output dec_pc, dec_stall
    );

endinterface

// File: rtl/decode_sched_inst_fifo.sv
// Small instruction FIFO with synchronous clear.
// Head is a straight read of the oldest slot.
module inst_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && (count != '0) && !clr;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/decode_sched.sv
// Decode scheduler: instruction buffer, load-use bubble
// insertion, redirect squash and a stall-cycle counter.
module decode_sched
    import decode_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decode_sched_if.slave        bus,
    input  logic                 flush,
    output logic [15:0]          stall_cycles
);

    localparam int CW = $clog2(DEPTH+1);

    logic [CW-1:0]     count;
    logic              full;
    logic [2*XLEN-1:0] head;
    logic              nonempty;
    logic              hazard;
    logic              issue;
    logic              push;
    logic              is_load;
    sched_state_t      state;
    logic [4:0]        lrd;

    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (push),
        .pop   (issue),
        .din   ({bus.if_pc, bus.if_instr}),
        .head  (head),
        .count (count),
        .full  (full)
    );

    assign nonempty = (count != '0);
    assign push     = bus.if_valid && !full && !flush;

    assign bus.if_ready  = !full;
    assign bus.dec_instr = nonempty ? head[XLEN-1:0] : INSTR_NOP;
    assign bus.dec_pc    = nonempty ? head[2*XLEN-1:XLEN] : '0;

    // x0 as a load target never blocks anything
    assign hazard = (state == SCHED_SHADOW) && (lrd != '0) &&
                    ((bus.dec_adr1 == lrd) || (bus.dec_adr2 == lrd));

    assign bus.dec_valid = nonempty && !hazard && !flush;
    assign bus.dec_stall = nonempty && hazard && !flush;
    assign issue         = bus.dec_valid && bus.ex_ready;

    assign is_load = (bus.dec_instr[6:0] == OPC_LOAD) &&
                     (bus.dec_instr[11:7] != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCHED_RUN;
            lrd   <= '0;
        end else if (flush) begin
            state <= SCHED_RUN;
            lrd   <= '0;
        end else if (issue && is_load) begin
            state <= SCHED_SHADOW;
            lrd   <= bus.dec_instr[11:7];
        end else if (bus.ex_ready) begin
            state <= SCHED_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (bus.dec_stall && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
    end

endmodule

// File: tb/tb_decode_sched.sv
// Randomised bench for decode_sched against a queue-based model.
// Directed load-use, flush, fill, saturation and async reset cases.
module tb_decode_sched;

    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [15:0] stall_cycles;

    decode_sched_if bus ();

    decode_sched #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .flush        (flush),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] q[$];
    logic        lp;
    logic [4:0]  lrd;
    int          sc;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 2))
            0: return {12'h000, rs1, 3'b010, rd, 7'b0000011};
            1: return {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
            default: return {12'h001, rs1, 3'b000, rd, 7'b0010011};
        endcase
    endfunction

    // One clock: drive inputs after the edge, check, advance model.
    task automatic step(input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic er,
                        input logic fl);
        logic        ne;
        logic [31:0] hi;
        logic [31:0] hp;
        logic        hz;
        logic        ev;
        logic        es;
        logic        rdy;
        @(posedge clk);
        #1;
        ne = (q.size() != 0);
        hi = ne ? q[0][31:0] : NOP;
        hp = ne ? q[0][63:32] : 32'h0;
        bus.if_valid = v;
        bus.if_instr = ins;
        bus.if_pc    = pc;
        bus.ex_ready = er;
        bus.dec_adr1 = hi[19:15];
        bus.dec_adr2 = hi[24:20];
        flush        = fl;
        #1;
        hz  = lp && (lrd != 0) &&
              (hi[19:15] == lrd || hi[24:20] == lrd);
        ev  = ne && !hz && !fl;
        es  = ne && hz && !fl;
        rdy = (q.size() < DEPTH);
        chk("if_ready", 64'(bus.if_ready), 64'(rdy));
        chk("dec_valid", 64'(bus.dec_valid), 64'(ev));
        chk("dec_stall", 64'(bus.dec_stall), 64'(es));
        chk("dec_instr", 64'(bus.dec_instr), 64'(hi));
        chk("dec_pc", 64'(bus.dec_pc), 64'(hp));
        chk("stall_cycles", 64'(stall_cycles), 64'(sc));
        if (es && sc < 65535)
            sc++;
        if (fl) begin
            q.delete();
            lp  = 1'b0;
            lrd = '0;
        end else begin
            if (ev && er) begin
                void'(q.pop_front());
                if (hi[6:0] == 7'b0000011 && hi[11:7] != 0) begin
                    lp  = 1'b1;
                    lrd = hi[11:7];
                end else begin
                    lp = 1'b0;
                end
            end else if (er) begin
                lp = 1'b0;
            end
            if (v && rdy)
                q.push_back({pc, ins});
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++)
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic reset_model();
        q.delete();
        lp  = 1'b0;
        lrd = '0;
        sc  = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_if_ready"}, 64'(bus.if_ready), 64'(1'b1));
        chk({tag, "_dec_valid"}, 64'(bus.dec_valid), 64'(1'b0));
        chk({tag, "_dec_stall"}, 64'(bus.dec_stall), 64'(1'b0));
        chk({tag, "_dec_instr"}, 64'(bus.dec_instr), 64'(NOP));
        chk({tag, "_dec_pc"}, 64'(bus.dec_pc), 64'h0);
        chk({tag, "_stall_cycles"}, 64'(stall_cycles), 64'h0);
    endtask

    localparam logic [31:0] ADDI_X1 = 32'h0050_0093;
    localparam logic [31:0] LW_X5   = 32'h0020_A283;
    localparam logic [31:0] ADD_X6  = 32'h0022_8333;
    localparam logic [31:0] LW_X0   = 32'h0020_A003;
    localparam logic [31:0] ADD_X0  = 32'h0000_0333;
    localparam logic [31:0] ADDI_X7 = 32'h0014_0393;

    int sc0;

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        bus.if_valid = 1'b0;
        bus.if_instr = '0;
        bus.if_pc    = '0;
        bus.ex_ready = 1'b0;
        bus.dec_adr1 = '0;
        bus.dec_adr2 = '0;
        reset_model();
        #3;
        chk_reset_outputs("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single addi: visible one cycle after enqueue, then issues
        step(1'b1, ADDI_X1, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("addi_valid", 64'(bus.dec_valid), 64'(1'b1));
        chk("addi_instr", 64'(bus.dec_instr), 64'(ADDI_X1));
        chk("addi_pc", 64'(bus.dec_pc), 64'h0);
        drain();

        // fill with execute stalled, then release
        step(1'b1, 32'h0000_0113, 32'h10, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0193, 32'h14, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0213, 32'h18, 1'b0, 1'b0);
        chk("fill_if_ready", 64'(bus.if_ready), 64'(1'b0));
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("fill_head", 64'(bus.dec_pc), 64'h10);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("fill_second", 64'(bus.dec_pc), 64'h14);
        drain();
        chk("fill_ready_back", 64'(bus.if_ready), 64'(1'b1));

        // load-use: exactly one bubble
        sc0 = sc;
        step(1'b1, LW_X5, 32'h20, 1'b1, 1'b0);
        step(1'b1, ADD_X6, 32'h24, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("lu_stall", 64'(bus.dec_stall), 64'(1'b1));
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("lu_issue", 64'(bus.dec_valid), 64'(1'b1));
        chk("lu_count", 64'(stall_cycles), 64'(sc0 + 1));
        drain();

        // load to x0 never stalls
        step(1'b1, LW_X0, 32'h30, 1'b1, 1'b0);
        step(1'b1, ADD_X0, 32'h34, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("x0_nostall", 64'(bus.dec_stall), 64'(1'b0));
        drain();

        // independent consumer never stalls
        step(1'b1, LW_X5, 32'h40, 1'b1, 1'b0);
        step(1'b1, ADDI_X7, 32'h44, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("indep_nostall", 64'(bus.dec_stall), 64'(1'b0));
        drain();

        // flush with two queued and a new offer
        step(1'b1, 32'h0000_0113, 32'h50, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0193, 32'h54, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0213, 32'h58, 1'b1, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("flush_valid", 64'(bus.dec_valid), 64'(1'b0));
        chk("flush_instr", 64'(bus.dec_instr), 64'(NOP));
        chk("flush_ready", 64'(bus.if_ready), 64'(1'b1));
        drain();

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, rnd_instr(),
                 {$urandom_range(0, 1023), 2'b00},
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0);
        drain();

        // saturate the stall counter
        step(1'b1, LW_X5, 32'h60, 1'b1, 1'b0);
        step(1'b1, ADD_X6, 32'h64, 1'b1, 1'b0);
        for (int i = 0; i < 70000; i++)
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("sat_count", 64'(stall_cycles), 64'hFFFF);

        // asynchronous reset in the middle of the stall
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        reset_model();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 3) != 0, rnd_instr(),
                 {$urandom_range(0, 1023), 2'b00},
                 $urandom_range(0, 3) != 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
